dmem_io: RTL and testbench

Data-side responder for the 8-bit minesweeper CPU. Serves the CPU's data port:
- stores on write strobe `MW`,
- returns read data on `Din` combinationally in the same cycle, as the single-cycle datapath requires.

Behind the port it holds 224 bytes of data RAM and a bank of memory-mapped I/O registers: sticky button flags, switches, tick timer, LFSR random source, LED and display registers. It sits between the CPU and the board pins.

---
 rtl/dmem_io.sv | 189 ++++++++++++++++++
 tb/tb_dmem_io.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/dmem_io.sv
// dmem_io: data-side responder for the 8-bit minesweeper CPU (224-byte RAM plus memory-mapped I/O).
// Optional button debounce is enabled by defining DMEM_IO_DEBOUNCE_EN.
module dmem_io #(
  parameter int TICK_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] ADDR,
  input  logic [7:0] WDATA,
  input  logic       MW,
  input  logic       RE,
  output logic [7:0] Din,
  input  logic [4:0] BTN,
  input  logic [7:0] SW,
  output logic [7:0] LED,
  output logic [7:0] DISP
);

  localparam logic [7:0] ADDR_BTN   = 8'hE0;
  localparam logic [7:0] ADDR_SW    = 8'hE1;
  localparam logic [7:0] ADDR_TICK  = 8'hE2;
  localparam logic [7:0] ADDR_RAND  = 8'hE3;
  localparam logic [7:0] ADDR_LED   = 8'hE4;
  localparam logic [7:0] ADDR_DISP  = 8'hE5;
  localparam logic [7:0] RAM_TOP    = 8'hE0;
  localparam logic [7:0] LFSR_SEED  = 8'hA5;
  localparam logic [7:0] LFSR_TAPS  = 8'hB8;

  localparam int             PS_W    = $clog2(TICK_DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  if (TICK_DIV < 2 || DEBOUNCE_CYCLES < 1) begin : gParamCheck
    $error("dmem_io: TICK_DIV must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  function automatic logic [7:0] lfsrStep(input logic [7:0] r);
    lfsrStep = r[0] ? ((r >> 1) ^ LFSR_TAPS) : (r >> 1);
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by the reset seed.
  function automatic logic [7:0] lfsrLoad(input logic [7:0] d);
    lfsrLoad = (d == 8'h00) ? LFSR_SEED : d;
  endfunction

  logic [7:0]      ram [0:223];
  logic [4:0]      btnSync1, btnSync2;
  logic [4:0]      btnLevel, btnPrev, btnRise;
  logic [4:0]      btnFlags;
  logic [7:0]      swSync1, swSync2;
  logic [PS_W-1:0] prescale;
  logic [7:0]      tick;
  logic [7:0]      lfsr;
  logic            ramSel, clearFlags, tickTerm;

  assign ramSel     = (ADDR < RAM_TOP);
  assign clearFlags = RE && (ADDR == ADDR_BTN);
  assign tickTerm   = (prescale == PS_LAST);

  // RAM: no reset; writes are dropped while RESET is held
  always_ff @(posedge CLK) begin
    if (MW && ramSel && !RESET) begin
      ram[ADDR] <= WDATA;
    end
  end

  // Input synchronizers for buttons and switches
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      btnSync1 <= '0;
      btnSync2 <= '0;
      swSync1  <= '0;
      swSync2  <= '0;
    end else begin
      btnSync1 <= BTN;
      btnSync2 <= btnSync1;
      swSync1  <= SW;
      swSync2  <= swSync1;
    end
  end

`ifdef DMEM_IO_DEBOUNCE_EN
  localparam int             DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] dbCnt [5];

  // Accepted level flips only after the raw level disagrees for DEBOUNCE_CYCLES straight cycles
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      btnLevel <= '0;
      for (int i = 0; i < 5; i++) begin
        dbCnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (btnSync2[i] != btnLevel[i]) begin
          if (dbCnt[i] == DB_LAST) begin
            btnLevel[i] <= btnSync2[i];
            dbCnt[i]    <= '0;
          end else begin
            dbCnt[i] <= dbCnt[i] + 1'b1;
          end
        end else begin
          dbCnt[i] <= '0;
        end
      end
    end
  end
`else
  assign btnLevel = btnSync2;
`endif

  assign btnRise = btnLevel & ~btnPrev;

  // Sticky flags: a same-cycle set survives the clear-on-read
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      btnPrev  <= '0;
      btnFlags <= '0;
    end else begin
      btnPrev <= btnLevel;
      if (clearFlags) begin
        btnFlags <= btnRise;
      end else begin
        btnFlags <= btnFlags | btnRise;
      end
    end
  end

  // Tick prescaler and counter; CPU writes override the increment
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prescale <= '0;
      tick     <= '0;
    end else begin
      if (tickTerm) begin
        prescale <= '0;
      end else begin
        prescale <= prescale + 1'b1;
      end
      if (MW && (ADDR == ADDR_TICK)) begin
        tick <= WDATA;
      end else if (tickTerm) begin
        tick <= tick + 8'd1;
      end
    end
  end

  // LFSR and output registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lfsr <= LFSR_SEED;
      LED  <= '0;
      DISP <= '0;
    end else begin
      if (MW && (ADDR == ADDR_RAND)) begin
        lfsr <= lfsrLoad(WDATA);
      end else begin
        lfsr <= lfsrStep(lfsr);
      end
      if (MW && (ADDR == ADDR_LED)) begin
        LED <= WDATA;
      end
      if (MW && (ADDR == ADDR_DISP)) begin
        DISP <= WDATA;
      end
    end
  end

  // Zero-latency read mux
  always_comb begin
    Din = 8'h00;
    if (ramSel) begin
      Din = ram[ADDR];
    end else begin
      unique case (ADDR)
        ADDR_BTN:  Din = {3'b000, btnFlags};
        ADDR_SW:   Din = swSync2;
        ADDR_TICK: Din = tick;
        ADDR_RAND: Din = lfsr;
        ADDR_LED:  Din = LED;
        ADDR_DISP: Din = DISP;
        default:   Din = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_io.sv
// Directed bench for dmem_io with TICK_DIV=4 and DEBOUNCE_CYCLES=16.
module tb_dmem_io;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] ADDR, WDATA, SW;
  logic       MW, RE;
  logic [4:0] BTN;
  logic [7:0] Din, LED, DISP;

  int checks = 0;
  int errors = 0;

  dmem_io #(.TICK_DIV(4), .DEBOUNCE_CYCLES(16)) dut (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .WDATA(WDATA), .MW(MW), .RE(RE),
    .Din(Din), .BTN(BTN), .SW(SW), .LED(LED), .DISP(DISP)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [7:0] a, input string tag, input logic [7:0] exp);
    ADDR = a;
    #1;
    chk(tag, Din, exp);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic writeReg(input logic [7:0] a, input logic [7:0] d);
    ADDR = a; WDATA = d; MW = 1'b1;
    @(posedge CLK);
    #1;
    MW = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; ADDR = 8'h00; WDATA = 8'h00; MW = 1'b0; RE = 1'b0;
    BTN = 5'b0; SW = 8'h5A;
    #1;
    chk("reset_led", LED, 8'h00);
    chk("reset_disp", DISP, 8'h00);
    rd(8'hE0, "reset_flags", 8'h00);

    // release at t=2, first edge at t=5
    RESET = 1'b0;
    rd(8'hE3, "rand_0", 8'hA5);
    edges(1);
    chk("rand_1", Din, 8'hEA);
    edges(1);
    chk("rand_2", Din, 8'h75);
    rd(8'hE2, "tick_after2", 8'h00);
    edges(1);
    chk("tick_after3", Din, 8'h00);
    edges(1);
    chk("tick_after4", Din, 8'h01);
    writeReg(8'hE2, 8'hFF);
    chk("tick_write", Din, 8'hFF);
    edges(4);
    chk("tick_wrap", Din, 8'h00);

    writeReg(8'hE3, 8'h00);
    chk("rand_load0", Din, 8'hA5);
    writeReg(8'hE3, 8'h01);
    chk("rand_load1", Din, 8'h01);

    writeReg(8'h10, 8'h3C);
    writeReg(8'hDF, 8'h7E);
    rd(8'h10, "ram_10", 8'h3C);
    rd(8'hDF, "ram_df", 8'h7E);
    rd(8'hF0, "undef_f0", 8'h00);
    rd(8'hE1, "sw_read", 8'h5A);
    writeReg(8'hE1, 8'h55);
    chk("sw_ro", Din, 8'h5A);

`ifndef DMEM_IO_DEBOUNCE_EN
    BTN = 5'b00100;
    edges(2);
    rd(8'hE0, "btn_sync_lat", 8'h00);
    edges(1);
    chk("btn_set", Din, 8'h04);
    edges(1);
    BTN = 5'b00000;
    RE = 1'b1;
    rd(8'hE0, "btn_before_clr", 8'h04);
    edges(1);
    RE = 1'b0;
    #1;
    chk("btn_cleared", Din, 8'h00);
    BTN = 5'b00010;
    edges(1);
    BTN = 5'b00011;
    edges(2);
    chk("btn1_set", Din, 8'h02);
    RE = 1'b1;
    edges(1);
    RE = 1'b0;
    #1;
    chk("btn_set_wins", Din, 8'h01);
    BTN = 5'b00000;
`endif

    writeReg(8'hE4, 8'h81);
    writeReg(8'hE5, 8'h12);
    chk("led_wr", LED, 8'h81);
    chk("disp_wr", DISP, 8'h12);
    rd(8'hE4, "led_rd", 8'h81);
`ifndef DMEM_IO_DEBOUNCE_EN
    rd(8'hE0, "flags_pre_rst", 8'h01);
`endif

    // asynchronous reset between edges
    #1;
    RESET = 1'b1;
    #1;
    chk("rst_led", LED, 8'h00);
    chk("rst_disp", DISP, 8'h00);
    rd(8'hE0, "rst_flags", 8'h00);
    rd(8'hE3, "rst_rand", 8'hA5);
    ADDR = 8'h10; WDATA = 8'hEE; MW = 1'b1;
    @(posedge CLK);
    #1;
    MW = 1'b0;
    RESET = 1'b0;
    rd(8'h10, "ram_kept_10", 8'h3C);
    rd(8'hDF, "ram_kept_df", 8'h7E);

`ifdef DMEM_IO_DEBOUNCE_EN
    BTN = 5'b01000;
    edges(10);
    BTN = 5'b00000;
    edges(25);
    rd(8'hE0, "db_glitch", 8'h00);
    BTN = 5'b01000;
    edges(18);
    rd(8'hE0, "db_edge18", 8'h00);
    edges(1);
    chk("db_edge19", Din, 8'h08);
    edges(1);
    BTN = 5'b00000;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
